uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter, successor to the single-mode 8N1 transmitter.
- Frame format is set at elaboration: data width, parity none/even/odd, 1 or 2 stop bits.
- Byte source interface is valid/ready, with a one-entry holding register so frames can be sent back-to-back with no idle gap.
- Sits between a byte source (ROM reader, FIFO, command engine) and the tx pin.

Parameters:
- CLK_FREQ, 14745600, input clock frequency in Hz.
- BAUDRATE, 115200, line rate; DIV = CLK_FREQ/BAUDRATE (integer division); elaboration error if DIV < 2.
- DATA_WIDTH, 8, data bits per frame; legal range 5..9; elaboration error otherwise.
- PARITY, 0, 0 = none, 1 = even, 2 = odd; elaboration error for 3.
- STOP_BITS, 1, stop-bit count; 1 or 2 only.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  source has a byte on s_data.
- s_ready  output  1  holding register empty; byte accepted on a clk edge where s_valid && s_ready.
- s_data  input  DATA_WIDTH  byte to send; sampled only on the accept edge.
- tx_line  output  1  serial output, idle high.
- busy  output  1  high while a frame is on the line (state != IDLE).
- frame_done  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While rst_n = 0: tx_line = 1, s_ready = 1, busy = 0, frame_done = 0, holding register empty, state IDLE, baud counter 0.
  - All outputs are registered.
- Accept: on an edge with s_valid && s_ready, s_data goes into the holding register (hold_full = 1). s_ready = !hold_full, registered. While s_ready = 0, s_valid is ignored.
- Load: the shifter loads from hold when (state == IDLE && hold_full) or at the last cycle of the last stop bit with hold_full. hold_full clears on the load edge, so s_ready returns high the cycle after load.
- Latency: byte accepted at edge T0 with the line idle → tx_line = 0 (start bit) from edge T0+1.
- Bit timing:
  - Every bit lasts exactly DIV clk cycles, counted by the baud counter.
  - The baud counter clears on every frame load, so there is no phase carry-over from previous frames.
  - The strobe fires when count == DIV-1.
- States:
  - IDLE: waits for hold_full.
  - START: line 0.
  - DATA: DATA_WIDTH bits, LSB first, bit index counter.
  - PARITY: only if PARITY != 0.
  - STOP: STOP_BITS bits at 1.
  - Transitions happen on the strobe only.
  - From STOP, the last strobe goes to START (hold_full) or IDLE.
- Parity: even → parity bit = XOR of data bits; odd → its inverse.
- Frame length: DIV*(1 + DATA_WIDTH + (PARITY != 0) + STOP_BITS) cycles.
- frame_done: high for exactly the one cycle following the final strobe of the last stop bit. It pulses once per frame, including back-to-back frames.
- Back-to-back: with hold_full at the end of stop, tx_line goes 1 → 0 with zero idle cycles between frames, and busy stays high.
- Reset mid-frame: tx_line goes to 1 immediately (asynchronous). The in-flight frame and the held byte are discarded, with no frame_done.
- s_data changes while hold_full do not affect the frame in flight.

Decomposition:
- Package uart_pkg:
  - PARITY_NONE/EVEN/ODD constants.
  - tx state encoding (IDLE, START, DATA, PARITY, STOP).
  - Function frame_bits(DATA_WIDTH, PARITY, STOP_BITS).
- Sub-module uart_baud_gen (parameter DIV; ports clk, rst_n, clear, strobe):
  - Free-running modulo-DIV counter with synchronous clear.
  - Reusable by a matching receiver.

Test Plan:
- 8N1, DIV = 128, send 0x55 → tx_line 0,1,0,1,0,1,0,1,0,1, each 128 cycles; frame_done pulses 1280 cycles after the start bit begins; busy falls the same cycle.
- PARITY = 1, 8 data bits, 1 stop, send 0x07 → parity bit 1, frame 1408 cycles. PARITY = 2, STOP_BITS = 2, send 0x07 → parity bit 0, stop high for 256 cycles, frame 1536 cycles.
- s_valid held high with 0xA5 then 0x3C →
  - 0x3C is accepted one cycle after 0xA5 is loaded.
  - s_ready is low until the 0xA5 stop completes.
  - The 0x3C start bit is adjacent to the 0xA5 stop bit (no idle cycles).
  - Two frame_done pulses.
- Three bytes 0x01, 0x02, 0x03 presented continuously → 0x03 stalls (s_ready = 0) until 0x02 moves to the shifter; all three frames are on the line in order with no gaps.
- rst_n pulsed low mid-DATA of 0xF0 (bit 4) → tx_line = 1 asynchronously, s_ready = 1, busy = 0, no frame_done; a following byte 0x81 transmits bit-exact.
- DATA_WIDTH = 5, PARITY = 0, STOP_BITS = 1, send 0x1F → 7-bit frame 0,1,1,1,1,1,1, total 7*DIV cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter (and a matching receiver).
//   PARITY_NONE / PARITY_EVEN / PARITY_ODD : values of the PARITY parameter
//   tx_state_t                             : transmitter FSM state encoding
//   frame_bits()                           : bit periods in one frame for a given format
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Start bit + data bits + optional parity bit + stop bits.
    function automatic int frame_bits(input int data_width, input int parity, input int stop_bits);
        return 1 + data_width + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_frame_baud.sv
// uart_baud_gen: free-running modulo-DIV counter producing one bit-period strobe.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (counter to 0)
//   clear  : synchronous restart of the bit period (counter to 0 on the next edge)
//   strobe : high during the last cycle of each bit period (count == DIV-1)
module uart_baud_gen #(
    parameter int DIV = 128
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic strobe
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign strobe = (count == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with a one-entry holding register.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   s_valid    : source presents a byte on s_data
//   s_ready    : holding register empty (byte taken on s_valid && s_ready)
//   s_data     : byte to send, sampled only on the accept edge
//   tx_line    : serial output, idle high
//   busy       : a frame is on the line
//   frame_done : one-cycle pulse after the last stop bit of each frame
// Handshake: a byte moves on every rising clk edge where s_valid && s_ready are both
// high; s_valid is ignored while s_ready is low, and s_ready never depends on s_valid.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 14745600,
    parameter int BAUDRATE   = 115200,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  tx_line,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int            DIV       = CLK_FREQ / BAUDRATE;
    localparam int            BW        = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          PAR_INV   = (PARITY == PARITY_ODD);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_frame: CLK_FREQ/BAUDRATE must be at least 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
        $error("uart_tx_frame: DATA_WIDTH must be 5..9");
    end
    if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    tx_state_t             state_q, state_d;
    logic [BW-1:0]         bit_idx_q, bit_idx_d;
    logic                  stop_idx_q, stop_idx_d;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_q;
    logic                  strobe;
    logic                  accept;
    logic                  load;
    logic                  last_stop_strobe;
    logic                  tx_d;

    assign accept           = s_valid && s_ready;
    assign last_stop_strobe = (state_q == ST_STOP) && (stop_idx_q == STOP_LAST) && strobe;
    // Loading from the final stop strobe is what makes back-to-back frames gapless.
    assign load             = hold_full_q && ((state_q == ST_IDLE) || last_stop_strobe);

    // Restarting the bit period on every load keeps frames free of phase carry-over.
    uart_baud_gen #(
        .DIV(DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (load),
        .strobe(strobe)
    );

    // Holding register. Accept and load cannot coincide: accept needs it empty,
    // load needs it full.
    always_comb begin
        hold_full_d = hold_full_q;
        if (accept) begin
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            s_ready     <= 1'b1;
        end else begin
            if (accept) begin
                hold_q <= s_data;
            end
            hold_full_q <= hold_full_d;
            s_ready     <= !hold_full_d;
        end
    end

    // Frame data is copied out of the holding register so the next byte can be
    // accepted while this one is still on the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            par_q  <= 1'b0;
        end else if (load) begin
            data_q <= hold_q;
            par_q  <= (^hold_q) ^ PAR_INV;
        end
    end

    // FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
        end
    end

    // FSM: next state. Apart from a load, state only advances on the bit strobe.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        if (load) begin
            state_d = ST_START;
        end else if (strobe) begin
            case (state_q)
                ST_START: begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
                ST_DATA: begin
                    if (bit_idx_q == BIT_LAST) begin
                        state_d    = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                end
                ST_STOP: begin
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs. Decoded from the next state so the registered tx_line shows the
    // start bit on the edge right after the load.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_q[bit_idx_d];
            ST_PARITY: tx_d = par_q;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_line    <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tx_line    <= tx_d;
            busy       <= (state_d != ST_IDLE);
            frame_done <= last_stop_strobe;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame. Four instances at DIV = 128 cover 8N1, 8E1, 8O2 and 5N1.
// Expected line patterns are hand-computed; bit k of each pattern is the k-th bit
// period on the line (start bit = bit 0).
module tb_uart_tx_frame;

  localparam int DIV = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] sv;
  logic [8:0] sd [4];
  logic [3:0] rdy_w, tx_w, busy_w, done_w;

  int checks = 0;
  int failures = 0;

  logic [4095:0] tx_s, done_s, busy_s, rdy_s;

  uart_tx_frame #(.CLK_FREQ(14745600), .BAUDRATE(115200), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) dut_8n1 (
    .clk(clk), .rst_n(rst_n), .s_valid(sv[0]), .s_ready(rdy_w[0]), .s_data(sd[0][7:0]),
    .tx_line(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));

  uart_tx_frame #(.CLK_FREQ(14745600), .BAUDRATE(115200), .DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1)) dut_8e1 (
    .clk(clk), .rst_n(rst_n), .s_valid(sv[1]), .s_ready(rdy_w[1]), .s_data(sd[1][7:0]),
    .tx_line(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));

  uart_tx_frame #(.CLK_FREQ(14745600), .BAUDRATE(115200), .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(2)) dut_8o2 (
    .clk(clk), .rst_n(rst_n), .s_valid(sv[2]), .s_ready(rdy_w[2]), .s_data(sd[2][7:0]),
    .tx_line(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));

  uart_tx_frame #(.CLK_FREQ(14745600), .BAUDRATE(115200), .DATA_WIDTH(5), .PARITY(0), .STOP_BITS(1)) dut_5n1 (
    .clk(clk), .rst_n(rst_n), .s_valid(sv[3]), .s_ready(rdy_w[3]), .s_data(sd[3][4:0]),
    .tx_line(tx_w[3]), .busy(busy_w[3]), .frame_done(done_w[3]));

  // ---------------- driver / capture tasks ----------------
  task automatic send_byte(input int sel, input logic [8:0] val, output bit ok);
    @(negedge clk);
    sv[sel] = 1'b1;
    sd[sel] = val;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (rdy_w[sel] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    sv[sel] = 1'b0;
    sd[sel] = 9'h1FF ^ val;
  endtask

  // Leaves the caller on the first negedge where the line is low (sample index 0).
  task automatic wait_start(input int sel, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_w[sel] === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Sample index 0 is the current negedge, then one sample per following negedge.
  task automatic capture(input int sel, input int n);
    tx_s = '0; done_s = '0; busy_s = '0; rdy_s = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      tx_s[i]   = tx_w[sel];
      done_s[i] = done_w[sel];
      busy_s[i] = busy_w[sel];
      rdy_s[i]  = rdy_w[sel];
    end
  endtask

  function automatic int line_errs(input int base, input logic [15:0] frame, input int nbits);
    int e = 0;
    for (int i = 0; i < nbits * DIV; i++)
      if (tx_s[base + i] !== frame[i / DIV]) e++;
    return e;
  endfunction

  function automatic int done_errs(input int n, input int p0, input int p1, input int p2);
    int e = 0;
    for (int i = 0; i < n; i++)
      if (done_s[i] !== ((i == p0) || (i == p1) || (i == p2))) e++;
    return e;
  endfunction

  function automatic int busy_errs(input int n, input int hi_end);
    int e = 0;
    for (int i = 0; i < n; i++)
      if (busy_s[i] !== (i < hi_end)) e++;
    return e;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    sv = '0;
    for (int s = 0; s < 4; s++) sd[s] = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      checks++;
      if ({tx_w[s], rdy_w[s], busy_w[s], done_w[s]} !== 4'b1100) begin
        failures++;
        $display("FAIL reset_state inst%0d: tx/rdy/busy/done=%b expected 1100", s,
                 {tx_w[s], rdy_w[s], busy_w[s], done_w[s]});
      end
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({tx_w[0], rdy_w[0], busy_w[0], done_w[0]} !== 4'b1100) begin
      failures++;
      $display("FAIL idle_after_reset: tx/rdy/busy/done=%b expected 1100",
               {tx_w[0], rdy_w[0], busy_w[0], done_w[0]});
    end
  endtask

  task automatic test_8n1();
    int e;
    @(negedge clk);
    sv[0] = 1'b1;
    sd[0] = 9'h055;
    checks++;
    if (rdy_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL 8n1_ready_idle: s_ready=%b expected 1", rdy_w[0]);
    end
    @(posedge clk);
    @(negedge clk);
    sv[0] = 1'b0;
    sd[0] = 9'h0AA;
    checks++;
    if ({tx_w[0], rdy_w[0], busy_w[0]} !== 3'b100) begin
      failures++;
      $display("FAIL 8n1_after_accept: tx/rdy/busy=%b expected 100", {tx_w[0], rdy_w[0], busy_w[0]});
    end
    @(negedge clk);
    capture(0, 1284);
    checks++;
    if ({tx_s[0], rdy_s[0], busy_s[0]} !== 3'b011) begin
      failures++;
      $display("FAIL 8n1_latency: tx/rdy/busy=%b expected 011", {tx_s[0], rdy_s[0], busy_s[0]});
    end
    e = line_errs(0, 16'h02AA, 10);
    checks++;
    if (e != 0) begin
      failures++;
      $display("FAIL 8n1_line_0x55: %0d cycles differ, expected 0 differing cycles", e);
    end
    e = done_errs(1284, 1280, -1, -1);
    checks++;
    if (e != 0) begin
      failures++;
      $display("FAIL 8n1_frame_done: %0d cycles wrong, expected single pulse at 1280", e);
    end
    e = busy_errs(1284, 1280);
    checks++;
    if (e != 0) begin
      failures++;
      $display("FAIL 8n1_busy: %0d cycles wrong, expected high 0..1279 only", e);
    end
  endtask

  task automatic test_parity();
    bit ok;
    int e;
    // even parity, 0x07 -> parity 1, 11 bit periods
    send_byte(1, 9'h007, ok);
    wait_start(1, 50, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL 8e1_start_timeout: no start bit, expected one within 50 cycles");
    end else begin
      capture(1, 1412);
      e = line_errs(0, 16'h060E, 11);
      checks++;
      if (e != 0) begin
        failures++;
        $display("FAIL 8e1_line_0x07: %0d cycles differ, expected 0", e);
      end
      e = done_errs(1412, 1408, -1, -1);
      checks++;
      if (e != 0) begin
        failures++;
        $display("FAIL 8e1_frame_done: %0d cycles wrong, expected pulse at 1408", e);
      end
    end
    // odd parity, two stop bits, 0x07 -> parity 0, 12 bit periods
    send_byte(2, 9'h007, ok);
    wait_start(2, 50, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL 8o2_start_timeout: no start bit, expected one within 50 cycles");
    end else begin
      capture(2, 1540);
      e = line_errs(0, 16'h0C0E, 12);
      checks++;
      if (e != 0) begin
        failures++;
        $display("FAIL 8o2_line_0x07: %0d cycles differ, expected 0", e);
      end
      e = done_errs(1540, 1536, -1, -1) + busy_errs(1540, 1536);
      checks++;
      if (e != 0) begin
        failures++;
        $display("FAIL 8o2_done_busy: %0d cycles wrong, expected done at 1536, busy low from 1536", e);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int e;
    int t_a, t_b;
    t_a = 0; t_b = 0; ok = 1'b0;
    fork
      begin
        @(negedge clk);
        sv[0] = 1'b1;
        sd[0] = 9'h0A5;
        for (int i = 0; i < 4000 && rdy_w[0] !== 1'b1; i++) @(negedge clk);
        t_a = cyc;
        @(posedge clk);
        @(negedge clk);
        sd[0] = 9'h03C;
        for (int i = 0; i < 4000 && rdy_w[0] !== 1'b1; i++) @(negedge clk);
        t_b = cyc;
        @(posedge clk);
        @(negedge clk);
        sv[0] = 1'b0;
        sd[0] = 9'h0C3;
      end
      begin
        wait_start(0, 50, ok);
        if (ok) capture(0, 2564);
      end
    join
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL b2b_start_timeout: no start bit, expected one within 50 cycles");
    end
    checks++;
    if (t_b - t_a != 2) begin
      failures++;
      $display("FAIL b2b_accept_gap: 0x3C accepted %0d cycles after 0xA5, expected 2", t_b - t_a);
    end
    e = 0;
    for (int i = 0; i < 2564; i++)
      if (rdy_s[i] !== ((i == 0) || (i >= 1280))) e++;
    checks++;
    if (e != 0) begin
      failures++;
      $display("FAIL b2b_ready: %0d cycles wrong, expected low 1..1279 only", e);
    end
    e = line_errs(0, 16'h034A, 10);
    checks++;
    if (e != 0) begin
      failures++;
      $display("FAIL b2b_line_0xA5: %0d cycles differ, expected 0", e);
    end
    e = line_errs(1280, 16'h0278, 10);
    checks++;
    if (e != 0) begin
      failures++;
      $display("FAIL b2b_line_0x3C: %0d cycles differ (gap or data), expected 0", e);
    end
    e = done_errs(2564, 1280, 2560, -1) + busy_errs(2564, 2560);
    checks++;
    if (e != 0) begin
      failures++;
      $display("FAIL b2b_done_busy: %0d cycles wrong, expected done at 1280,2560 and busy 0..2559", e);
    end
  endtask

  task automatic test_three_bytes();
    bit ok;
    int e;
    logic [8:0] bytes [3];
    bytes[0] = 9'h001; bytes[1] = 9'h002; bytes[2] = 9'h003;
    ok = 1'b0;
    fork
      begin
        for (int b = 0; b < 3; b++) begin
          @(negedge clk);
          sv[0] = 1'b1;
          sd[0] = bytes[b];
          for (int i = 0; i < 4000 && rdy_w[0] !== 1'b1; i++) @(negedge clk);
          @(posedge clk);
        end
        @(negedge clk);
        sv[0] = 1'b0;
      end
      begin
        wait_start(0, 50, ok);
        if (ok) capture(0, 3844);
      end
    join
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL three_start_timeout: no start bit, expected one within 50 cycles");
    end
    e = 0;
    for (int i = 0; i < 3844; i++)
      if (rdy_s[i] !== ((i == 0) || (i == 1280) || (i >= 2560))) e++;
    checks++;
    if (e != 0) begin
      failures++;
      $display("FAIL three_ready_stall: %0d cycles wrong, expected high only at 0, 1280, >=2560", e);
    end
    e = line_errs(0, 16'h0202, 10) + line_errs(1280, 16'h0204, 10) + line_errs(2560, 16'h0206, 10);
    checks++;
    if (e != 0) begin
      failures++;
      $display("FAIL three_line: %0d cycles differ over 0x01,0x02,0x03, expected 0", e);
    end
    e = done_errs(3844, 1280, 2560, 3840);
    checks++;
    if (e != 0) begin
      failures++;
      $display("FAIL three_done: %0d cycles wrong, expected pulses at 1280,2560,3840", e);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int e, lows;
    send_byte(0, 9'h0F0, ok);
    send_byte(0, 9'h055, ok);   // 0x55 now sits in the holding register
    repeat (703) @(negedge clk); // mid data bit 4 of 0xF0
    checks++;
    if ({busy_w[0], rdy_w[0]} !== 2'b10) begin
      failures++;
      $display("FAIL midframe_pre: busy/rdy=%b expected 10", {busy_w[0], rdy_w[0]});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_w[0], rdy_w[0], busy_w[0], done_w[0]} !== 4'b1100) begin
      failures++;
      $display("FAIL midframe_async_reset: tx/rdy/busy/done=%b expected 1100",
               {tx_w[0], rdy_w[0], busy_w[0], done_w[0]});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0) e++;
      if (tx_w[0] !== 1'b1) lows++;
    end
    checks++;
    if (e != 0 || lows != 0) begin
      failures++;
      $display("FAIL midframe_discard: done cycles=%0d line-low cycles=%0d, expected 0 and 0", e, lows);
    end
    send_byte(0, 9'h081, ok);
    wait_start(0, 50, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL post_reset_start_timeout: no start bit, expected one within 50 cycles");
    end else begin
      capture(0, 1284);
      e = line_errs(0, 16'h0302, 10) + done_errs(1284, 1280, -1, -1);
      checks++;
      if (e != 0) begin
        failures++;
        $display("FAIL post_reset_0x81: %0d cycles wrong, expected 0", e);
      end
    end
  endtask

  task automatic test_5n1();
    bit ok;
    int e;
    send_byte(3, 9'h01F, ok);
    wait_start(3, 50, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL 5n1_start_timeout: no start bit, expected one within 50 cycles");
    end else begin
      capture(3, 900);
      e = line_errs(0, 16'h007E, 7);
      checks++;
      if (e != 0) begin
        failures++;
        $display("FAIL 5n1_line_0x1F: %0d cycles differ, expected 0", e);
      end
      e = done_errs(900, 896, -1, -1) + busy_errs(900, 896);
      checks++;
      if (e != 0) begin
        failures++;
        $display("FAIL 5n1_done_busy: %0d cycles wrong, expected done at 896, busy 0..895", e);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_three_bytes();
    test_reset_mid_frame();
    test_5n1();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded 3 ms, expected completion well before");
    $fatal(1, "watchdog expired");
  end

endmodule
